openofdm_tx_scramble_fcs: RTL and testbench

//  TX-side byte front end of the OFDM PHY; it is the transmit counterpart of the RX byte/FCS output path.
//  Per packet it emits, in order: the 2-byte SERVICE field (zero), the PSDU payload taken from the MAC,
//  and a 4-byte CRC-32 FCS that it computes itself. Every emitted bit passes through the 802.11 x^7+x^4+1

---
 rtl/openofdm_tx_scramble_fcs.sv | 149 ++++++++++++++
 tb/tb_openofdm_tx_scramble_fcs.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/openofdm_tx_scramble_fcs.sv
// TX byte front end: SERVICE(2x00) + PSDU payload + CRC-32 FCS, all through the x^7+x^4+1 scrambler.
// One-deep output register with valid/ready; payload accepted straight into it (1-cycle latency).
module openofdm_tx_scramble_fcs #(
   parameter int LEN_WIDTH = 16
) (
   input  logic                 s00_axi_aclk,
   input  logic                 s00_axi_aresetn,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] pkt_len,
   input  logic [6:0]           scram_seed,
   input  logic                 scram_bypass,
   input  logic [7:0]           byte_in,
   input  logic                 byte_in_valid,
   output logic                 byte_in_ready,
   output logic [7:0]           byte_out,
   output logic                 byte_out_valid,
   input  logic                 byte_out_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 len_err,
   output logic [LEN_WIDTH-1:0] byte_count
);

   typedef enum logic [1:0] {IDLE, SERVICE, DATA, FCS} state_t;

   state_t               state, state_nx;
   logic [LEN_WIDTH-1:0] len_q;
   logic                 bypass_q;
   logic [6:0]           scr;
   logic [31:0]          crc, fcs;
   logic [2:0]           idx;
   logic                 load_ok, xfer, in_acc, load, start_ok, last_in, fcs_end;
   logic [7:0]           load_byte;
   logic [14:0]          scr_res;

   // Returns {next_state, out_byte}; bit0 goes through the LFSR first.
   function automatic logic [14:0] scramble(input logic [6:0] s_in, input logic [7:0] d, input logic byp);
      logic [6:0] s;
      logic [7:0] o;
      logic       fb;
      s = s_in;
      o = d;
      for (int i = 0; i < 8; i++) begin
         fb = s[6] ^ s[3];
         if (!byp) o[i] = d[i] ^ fb;
         s = {s[5:0], fb};
      end
      return {s, o};
   endfunction

   function automatic logic [31:0] crc8(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++)
         c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   assign load_ok  = !byte_out_valid || byte_out_ready;
   assign xfer     = byte_out_valid && byte_out_ready;
   assign start_ok = start && (pkt_len >= LEN_WIDTH'(5));
   assign in_acc   = byte_in_valid && byte_in_ready;
   assign last_in  = (byte_count == len_q - LEN_WIDTH'(5));
   assign fcs_end  = (state == FCS) && (idx == 3'd4) && xfer;
   assign fcs      = ~crc;
   assign scr_res  = scramble(scr, load_byte, bypass_q);

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) state <= IDLE;
      else                  state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_ok) state_nx = SERVICE;
         SERVICE: if (load_ok && idx == 3'd1) state_nx = DATA;
         DATA:    if (in_acc && last_in) state_nx = FCS;
         FCS:     if (fcs_end) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      byte_in_ready = 1'b0;
      load          = 1'b0;
      load_byte     = 8'h00;
      case (state)
         SERVICE: load = load_ok;
         DATA: begin
            byte_in_ready = load_ok;
            load          = load_ok && byte_in_valid;
            load_byte     = byte_in;
         end
         // idx==4: last FCS byte is sitting in the output register, only drain it
         FCS: begin
            load      = load_ok && (idx != 3'd4);
            load_byte = fcs[{idx[1:0], 3'b000} +: 8];
         end
         default: ;
      endcase
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         len_q          <= '0;
         bypass_q       <= 1'b0;
         scr            <= 7'h7F;
         crc            <= 32'hFFFFFFFF;
         idx            <= 3'd0;
         byte_out       <= 8'h00;
         byte_out_valid <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         len_err        <= 1'b0;
         byte_count     <= '0;
      end else begin
         done    <= fcs_end;
         len_err <= (state == IDLE) && start && !start_ok;
         if (state == IDLE && start_ok) begin
            len_q      <= pkt_len;
            bypass_q   <= scram_bypass;
            byte_count <= '0;
            crc        <= 32'hFFFFFFFF;
            scr        <= (scram_seed == 7'd0) ? 7'h7F : scram_seed;
            busy       <= 1'b1;
            idx        <= 3'd0;
         end
         if (fcs_end) begin
            busy <= 1'b0;
            idx  <= 3'd0;
         end
         if (load) begin
            byte_out       <= scr_res[7:0];
            scr            <= scr_res[14:8];
            byte_out_valid <= 1'b1;
         end else if (xfer) begin
            byte_out_valid <= 1'b0;
         end
         if (in_acc) begin
            crc        <= crc8(crc, byte_in);
            byte_count <= byte_count + LEN_WIDTH'(1);
         end
         if (load && state == SERVICE) idx <= (idx == 3'd1) ? 3'd0 : idx + 3'd1;
         if (load && state == FCS)     idx <= idx + 3'd1;
      end
   end

endmodule

// File: tb/tb_openofdm_tx_scramble_fcs.sv
// Directed bench for openofdm_tx_scramble_fcs: vector table of packets plus hand sequences
// for length rejection, mid-packet reset and ignored restart.
module tb_openofdm_tx_scramble_fcs;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] pkt_len = '0;
   logic [6:0]  scram_seed = '0;
   logic        scram_bypass = 1'b0;
   logic [7:0]  byte_in = '0;
   logic        byte_in_valid = 1'b0;
   logic        byte_in_ready;
   logic [7:0]  byte_out;
   logic        byte_out_valid;
   logic        byte_out_ready = 1'b0;
   logic        busy, done, len_err;
   logic [15:0] byte_count;

   always #5 clk = ~clk;

   openofdm_tx_scramble_fcs #(.LEN_WIDTH(16)) dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .start(start), .pkt_len(pkt_len),
      .scram_seed(scram_seed), .scram_bypass(scram_bypass), .byte_in(byte_in),
      .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready), .byte_out(byte_out),
      .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready), .busy(busy),
      .done(done), .len_err(len_err), .byte_count(byte_count)
   );

   typedef struct {
      int           len;
      logic [6:0]   seed;
      bit           byp;
      bit           rnd;
      logic [127:0] pay;   // byte i at [8*i +: 8]
      int           nexp;  // leading output bytes with hand-computed values
      logic [127:0] hexp;
   } vec_t;

   int         errs = 0;
   int         checks = 0;
   logic [7:0] pay[0:63];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   vec_t       vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference stream: 00 00, payload, ~CRC LSB first, then the scrambler bit by bit.
   task automatic build_exp(input int len, input logic [6:0] seed, input bit byp);
      logic [7:0]  raw[$];
      logic [31:0] c;
      logic [6:0]  s;
      logic [7:0]  d;
      logic        fb;
      raw = {};
      raw.push_back(8'h00);
      raw.push_back(8'h00);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len - 4; i++) begin
         raw.push_back(pay[i]);
         for (int b = 0; b < 8; b++)
            c = ((c[0] ^ pay[i][b]) != 1'b0) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) raw.push_back(c[8*k +: 8]);
      s = (seed == 7'd0) ? 7'h7F : seed;
      exp_q = {};
      for (int i = 0; i < raw.size(); i++) begin
         d = raw[i];
         for (int b = 0; b < 8; b++) begin
            fb = s[6] ^ s[3];
            if (!byp) d[b] = d[b] ^ fb;
            s = {s[5:0], fb};
         end
         exp_q.push_back(d);
      end
   endtask

   task automatic run_vec(input vec_t v, input int abort_after, input bit restart, input string tag);
      int         npay, pi, done_cnt, busy_cyc;
      bit         hold, finished, rs_done;
      logic [7:0] hold_byte;
      npay = v.len - 4;
      for (int i = 0; i < npay; i++) pay[i] = v.pay[8*i +: 8];
      build_exp(v.len, v.seed, v.byp);
      got_q = {};
      pi = 0; done_cnt = 0; busy_cyc = 0;
      hold = 0; finished = 0; rs_done = 0; hold_byte = 8'h00;
      @(negedge clk);
      start = 1'b1; pkt_len = 16'(v.len); scram_seed = v.seed; scram_bypass = v.byp;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (hold) chk({tag, " hold"}, {23'd0, byte_out_valid, byte_out}, {23'd0, 1'b1, hold_byte});
         if (busy) busy_cyc++;
         if (done) begin
            done_cnt++;
            chk({tag, " busy_after_done"}, {31'd0, busy}, 32'd0);
            finished = 1;
            break;
         end
         if (abort_after >= 0 && pi == abort_after) begin
            rst_n = 1'b0;
            #1;
            chk({tag, " outputs_in_reset"},
                {3'd0, byte_out_valid, byte_out, busy, done, len_err, byte_count, byte_in_ready}, 32'd0);
            byte_in_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         start = restart && pi == 2 && !rs_done;
         if (start) begin
            rs_done = 1; pkt_len = 16'd5; scram_seed = 7'h15; scram_bypass = ~v.byp;
         end
         byte_out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         byte_in_valid  = (pi < npay) && (v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
         byte_in        = (pi < npay) ? pay[pi] : 8'h00;
         #1;
         if (byte_out_valid && byte_out_ready) got_q.push_back(byte_out);
         if (byte_in_valid && byte_in_ready) pi++;
         hold = byte_out_valid && !byte_out_ready;
         hold_byte = byte_out;
      end
      start = 1'b0;
      byte_in_valid = 1'b0;
      chk({tag, " finished"}, {31'd0, finished}, 32'd1);
      repeat (3) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, " byte_count"}, {16'd0, byte_count}, 32'(npay));
      chk({tag, " out_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      if (v.len == 5 && !v.rnd) chk({tag, " busy_7plus"}, {31'd0, busy_cyc >= 7}, 32'd1);
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         if (i < v.nexp) chk($sformatf("%s byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, v.hexp[8*i +: 8]});
         else            chk($sformatf("%s byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      end
   endtask

   initial begin
      vecs[0] = '{len: 5,  seed: 7'h7F, byp: 1'b0, rnd: 1'b0, pay: 128'h00, nexp: 7,
                  hexp: 128'hBF768BCD934F70};
      vecs[1] = '{len: 13, seed: 7'h7F, byp: 1'b1, rnd: 1'b0, pay: 128'h393837363534333231, nexp: 15,
                  hexp: 128'hCBF43926393837363534333231_0000};
      vecs[2] = vecs[1];
      vecs[2].rnd = 1'b1;
      vecs[3] = vecs[0];
      vecs[3].seed = 7'h00;
      vecs[4] = '{len: 6,  seed: 7'h25, byp: 1'b0, rnd: 1'b0, pay: 128'h55AA, nexp: 0, hexp: 128'h0};
      vecs[5] = '{len: 20, seed: 7'h11, byp: 1'b0, rnd: 1'b1, pay: 128'h0, nexp: 0, hexp: 128'h0};
      for (int i = 0; i < 16; i++) vecs[5].pay[8*i +: 8] = 8'(8'hC3 + 8'(i * 29));

      #12;
      chk("reset_state", {3'd0, byte_out_valid, byte_out, busy, done, len_err, byte_count, byte_in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], -1, 1'b0, $sformatf("vec%0d", i));

      // Too-short packet is rejected with a single len_err pulse
      @(negedge clk);
      start = 1'b1; pkt_len = 16'd4;
      @(negedge clk);
      start = 1'b0;
      chk("len_err_pulse", {31'd0, len_err}, 32'd1);
      chk("len_err_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("len_err_oneshot", {31'd0, len_err}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("len_err_no_output", {30'd0, byte_out_valid, busy}, 32'd0);
      end
      run_vec(vecs[4], -1, 1'b0, "after_len_err");

      // Reset mid-DATA, then a clean packet from fresh state
      begin
         vec_t va;
         va = '{len: 10, seed: 7'h05, byp: 1'b0, rnd: 1'b0, pay: 128'h0F1E2D3C4B5A, nexp: 0, hexp: 128'h0};
         run_vec(va, 3, 1'b0, "abort");
         run_vec(va, -1, 1'b0, "post_abort");
      end

      // start during DATA must be ignored
      run_vec(vecs[1], -1, 1'b1, "restart_ignored");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
